ssd_scan_mux: RTL and testbench
===============================

# ssd_scan_mux

Time-multiplexing scanner that sits directly upstream of `ssd_driver` on the 7-segment display path. It holds a multi-digit hex value plus per-digit decimal points and cycles through the digits at a fixed refresh rate. Each cycle it presents one 4-bit nibble and its dp bit to `ssd_driver`, and drives the matching active-low anode. Display updates are double-buffered, so a new value only takes effect on a frame boundary and never tears mid-scan.

## Interface
- `NUM_DIGITS`, 8: number of scanned digits, legal 2..8.
- `REFRESH_DIV`, 100000: clock cycles per digit slot, must be ≥ 4.
- `GUARD_CYCLES`, 16: anode-off cycles at the start of each slot (anti-ghosting), must be < `REFRESH_DIV`.

Ports:
- `ssd_scan_port_clk` in 1: system clock.
- `ssd_scan_port_rst_n` in 1: reset, asynchronous and active-low.
- `ssd_scan_port_value` in 4*NUM_DIGITS: hex value; digit i = bits [4i+3:4i].
- `ssd_scan_port_dp` in NUM_DIGITS: dp request per digit, 1 = lit.
- `ssd_scan_port_en` in NUM_DIGITS: digit enable mask, 0 = digit dark.
- `ssd_scan_port_load` in 1: one-cycle strobe that captures value/dp into the pending buffer.
- `ssd_scan_port_nibble` out 4: current digit nibble, feeds `ssd_driver_port_in`.
- `ssd_scan_port_dp_out` out 1: current digit dp, feeds `ssd_driver_port_dp_in`.
- `ssd_scan_port_an` out NUM_DIGITS: anodes, active-low one-hot, all-ones = dark.
- `ssd_scan_port_frame_done` out 1: one-cycle pulse per completed frame.

## Operation
- Prescaler counts 0..REFRESH_DIV-1 and wraps. `tick` is asserted when the count equals REFRESH_DIV-1.
- Digit index (0..NUM_DIGITS-1) increments on each tick and wraps to 0 after NUM_DIGITS-1. That wrap tick is the frame boundary.
- Buffers are `active` (displayed) and `pending` (plus a pending-valid flag):
  - `load` copies value/dp into `pending` and sets the flag.
  - On a frame boundary with the flag set, `pending` moves to `active` and the flag clears.
  - `load` in the same cycle as the boundary: the incoming data goes straight to `active`, `pending` is untouched, and the flag clears.
  - Multiple loads within a frame: the last one wins.
- `ssd_scan_port_en` is sampled live, not buffered.
- Anode for the current index is low only when all hold: the digit is enabled, prescaler count ≥ GUARD_CYCLES, and the digit is not blanked. Otherwise `an` is all ones.
- `nibble`/`dp_out` always reflect the active digit, even while the anodes are dark.
- Reset (async assert, any time including mid-frame):
  - prescaler 0, index 0, `active` 0, `pending` 0, flag 0.
  - `an` all ones, `nibble` 0, `dp_out` 0, `frame_done` 0.
  - Scanning restarts at digit 0 on the first clock after deassertion.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- After a tick at cycle t, `nibble`/`dp_out` for the new index are valid at t+1. `an` stays all ones during t+1..t+GUARD_CYCLES and selects the digit from t+GUARD_CYCLES+1.
- `frame_done` is high for exactly the one cycle after the frame-boundary tick. It is the same cycle the newly transferred `active` data appears on `nibble`.
- Load-to-display latency: 1 cycle minimum (load on the boundary cycle), NUM_DIGITS*REFRESH_DIV cycles maximum.
- First `frame_done` after reset arrives NUM_DIGITS*REFRESH_DIV cycles after deassertion.

## Configuration
- `SSD_SCAN_BLANK_EN` defined: leading-zero blanking.
  - Digit i > 0 is blanked when it and every higher digit are 0 with dp clear.
  - A set dp on a digit stops blanking of that digit and all lower ones.
  - Digit 0 is never blanked.
  - Evaluated on `active`.
- `SSD_SCAN_BLANK_EN` undefined: no blanking logic; every enabled digit lights.

## Test plan
Bench parameters: NUM_DIGITS=4, REFRESH_DIV=4, GUARD_CYCLES=1.
- **Reset:** hold rst_n=0 for 5 cycles, then release → `an`=4'b1111, `nibble`=0, `frame_done`=0 during reset; first `frame_done` 16 cycles after release.
- **Scan order:** load value=16'h1234, dp=4'b0001, en=4'hF, then wait one frame → nibble sequence 4,3,2,1 at slots 0..3; `an` cycles 1110,1101,1011,0111 with one dark guard cycle per slot; `dp_out`=1 only in slot 0.
- **Tear-free update:** load 16'hAAAA mid-frame while 16'h1234 is displayed → remaining slots still show 3,2,1; 16'hAAAA appears after `frame_done`.
- **Boundary collision:** assert `load` with 16'h5555 in the exact frame-boundary tick cycle → slot 0 of the next frame shows 5; pending flag clear.
- **Enable mask:** en=4'b0101 → `an` never low for digits 1 and 3; digits 0 and 2 light normally.
- **Blanking:** with `SSD_SCAN_BLANK_EN`, value=16'h0012 → digits 3 and 2 dark, 1 and 0 lit. With value=16'h0000 and dp=4'b0100 → digits 2, 1 and 0 lit, digit 3 dark. Without the macro, all four lit.

Source files
------------

// File: rtl/ssd_scan_mux.sv
`default_nettype none
// ============================================================================
// Module      : ssd_scan_mux
// Description : Time-multiplexed 7-segment digit scanner. Holds a double-
//               buffered multi-digit hex value with per-digit decimal points.
//               It steps through the digits at a fixed refresh rate and drives
//               one nibble/dp pair plus an active-low one-hot anode. A guard
//               interval at the start of each slot keeps the anodes dark to
//               prevent ghosting.
//               Optional leading-zero blanking: define SSD_SCAN_BLANK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module ssd_scan_mux #(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_DIV  = 100000,
    parameter int GUARD_CYCLES = 16
) (
    input  logic                    ssd_scan_port_clk,
    input  logic                    ssd_scan_port_rst_n,
    input  logic [4*NUM_DIGITS-1:0] ssd_scan_port_value,
    input  logic [NUM_DIGITS-1:0]   ssd_scan_port_dp,
    input  logic [NUM_DIGITS-1:0]   ssd_scan_port_en,
    input  logic                    ssd_scan_port_load,
    output logic [3:0]              ssd_scan_port_nibble,
    output logic                    ssd_scan_port_dp_out,
    output logic [NUM_DIGITS-1:0]   ssd_scan_port_an,
    output logic                    ssd_scan_port_frame_done
);

    localparam int c_cw = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int c_iw = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int c_vw = 4 * NUM_DIGITS;
    localparam logic [c_cw-1:0] c_presc_max = c_cw'(REFRESH_DIV - 1);
    localparam logic [c_cw-1:0] c_guard     = c_cw'(GUARD_CYCLES);
    localparam logic [c_iw-1:0] c_idx_max   = c_iw'(NUM_DIGITS - 1);

    logic [c_cw-1:0]       r_presc;
    logic [c_iw-1:0]       r_idx;
    logic [c_vw-1:0]       r_act_val;
    logic [NUM_DIGITS-1:0] r_act_dp;
    logic [c_vw-1:0]       r_pend_val;
    logic [NUM_DIGITS-1:0] r_pend_dp;
    logic                  r_pend_vld;
    logic [3:0]            r_nibble;
    logic                  r_dp_out;
    logic [NUM_DIGITS-1:0] r_an;
    logic                  r_frame_done;

    logic                  w_tick;
    logic                  w_boundary;
    logic [c_cw-1:0]       w_presc_nx;
    logic [c_iw-1:0]       w_idx_nx;
    logic [c_vw-1:0]       w_act_val_nx;
    logic [NUM_DIGITS-1:0] w_act_dp_nx;
    logic [NUM_DIGITS-1:0] w_blank;
    logic                  w_light;
    logic [NUM_DIGITS-1:0] w_an_nx;
    logic [3:0]            w_nibble_nx;

    assign w_tick     = (r_presc == c_presc_max);
    assign w_boundary = w_tick && (r_idx == c_idx_max);

    // Next prescaler/index and next active buffer; outputs are computed from
    // these so that the registered outputs line up with the new slot.
    always_comb begin
        w_presc_nx   = w_tick ? '0 : r_presc + 1'b1;
        w_idx_nx     = r_idx;
        w_act_val_nx = r_act_val;
        w_act_dp_nx  = r_act_dp;
        if (w_tick) begin
            w_idx_nx = (r_idx == c_idx_max) ? '0 : r_idx + 1'b1;
        end
        if (w_boundary && ssd_scan_port_load) begin
            w_act_val_nx = ssd_scan_port_value;
            w_act_dp_nx  = ssd_scan_port_dp;
        end else if (w_boundary && r_pend_vld) begin
            w_act_val_nx = r_pend_val;
            w_act_dp_nx  = r_pend_dp;
        end
    end

`ifdef SSD_SCAN_BLANK_EN
    // Leading-zero blanking: a digit is dark while it and all digits above
    // it are zero with dp clear; digit 0 always lights.
    always_comb begin : p_blank
        logic v_run;
        w_blank = '0;
        v_run   = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            v_run      = v_run && (w_act_val_nx[4*i +: 4] == 4'h0) && !w_act_dp_nx[i];
            w_blank[i] = v_run;
        end
    end
`else
    assign w_blank = '0;
`endif

    // Anode select for the upcoming cycle; enable mask is sampled live.
    always_comb begin
        w_light     = ssd_scan_port_en[w_idx_nx] && (w_presc_nx >= c_guard) && !w_blank[w_idx_nx];
        w_an_nx     = '1;
        if (w_light) begin
            w_an_nx[w_idx_nx] = 1'b0;
        end
        w_nibble_nx = w_act_val_nx[{w_idx_nx, 2'b00} +: 4];
    end

    // Prescaler and digit index.
    always_ff @(posedge ssd_scan_port_clk or negedge ssd_scan_port_rst_n) begin
        if (!ssd_scan_port_rst_n) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else begin
            r_presc <= w_presc_nx;
            r_idx   <= w_idx_nx;
        end
    end

    // Double buffer: pending collects loads, active swaps on frame boundary.
    always_ff @(posedge ssd_scan_port_clk or negedge ssd_scan_port_rst_n) begin
        if (!ssd_scan_port_rst_n) begin
            r_act_val  <= '0;
            r_act_dp   <= '0;
            r_pend_val <= '0;
            r_pend_dp  <= '0;
            r_pend_vld <= 1'b0;
        end else begin
            r_act_val <= w_act_val_nx;
            r_act_dp  <= w_act_dp_nx;
            if (w_boundary) begin
                r_pend_vld <= 1'b0;
            end else if (ssd_scan_port_load) begin
                r_pend_val <= ssd_scan_port_value;
                r_pend_dp  <= ssd_scan_port_dp;
                r_pend_vld <= 1'b1;
            end
        end
    end

    // Registered display outputs.
    always_ff @(posedge ssd_scan_port_clk or negedge ssd_scan_port_rst_n) begin
        if (!ssd_scan_port_rst_n) begin
            r_nibble     <= 4'h0;
            r_dp_out     <= 1'b0;
            r_an         <= '1;
            r_frame_done <= 1'b0;
        end else begin
            r_nibble     <= w_nibble_nx;
            r_dp_out     <= w_act_dp_nx[w_idx_nx];
            r_an         <= w_an_nx;
            r_frame_done <= w_boundary;
        end
    end

    assign ssd_scan_port_nibble     = r_nibble;
    assign ssd_scan_port_dp_out     = r_dp_out;
    assign ssd_scan_port_an         = r_an;
    assign ssd_scan_port_frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_ssd_scan_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_ssd_scan_mux
// Description : Directed self-checking bench for ssd_scan_mux with 4 digits,
//               4 cycles per slot and 1 guard cycle. Expected tables follow
//               SSD_SCAN_BLANK_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ssd_scan_mux;

    logic        clk;
    logic        rst_n;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  en;
    logic        load;
    logic [3:0]  nibble;
    logic        dp_out;
    logic [3:0]  an;
    logic        frame_done;

    int n_checks = 0;
    int n_errors = 0;

    // Per-frame expectations; slot s sits in bits [4s+3:4s] (dp: bit s).
    logic [15:0] nib_f [8];
    logic [3:0]  dp_f  [8];
    logic [15:0] an_f  [8];

    ssd_scan_mux #(
        .NUM_DIGITS   (4),
        .REFRESH_DIV  (4),
        .GUARD_CYCLES (1)
    ) u_dut (
        .ssd_scan_port_clk        (clk),
        .ssd_scan_port_rst_n      (rst_n),
        .ssd_scan_port_value      (value),
        .ssd_scan_port_dp         (dp),
        .ssd_scan_port_en         (en),
        .ssd_scan_port_load       (load),
        .ssd_scan_port_nibble     (nibble),
        .ssd_scan_port_dp_out     (dp_out),
        .ssd_scan_port_an         (an),
        .ssd_scan_port_frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int f, s, c;
        nib_f[0] = 16'h0000; dp_f[0] = 4'b0000;
        nib_f[1] = 16'h1234; dp_f[1] = 4'b0001;
        nib_f[2] = 16'hAAAA; dp_f[2] = 4'b0000;
        nib_f[3] = 16'h5555; dp_f[3] = 4'b0000;
        nib_f[4] = 16'h5555; dp_f[4] = 4'b0000;
        nib_f[5] = 16'h0012; dp_f[5] = 4'b0000;
        nib_f[6] = 16'h0000; dp_f[6] = 4'b0100;
        nib_f[7] = 16'h8888; dp_f[7] = 4'b1111;
        an_f[1] = 16'h7BDE;
        an_f[2] = 16'h7BDE;
        an_f[3] = 16'h7BDE;
        an_f[4] = 16'hFBFE;
        an_f[7] = 16'h7BDE;
`ifdef SSD_SCAN_BLANK_EN
        an_f[0] = 16'hFFFE;
        an_f[5] = 16'hFFDE;
        an_f[6] = 16'hFBDE;
`else
        an_f[0] = 16'h7BDE;
        an_f[5] = 16'h7BDE;
        an_f[6] = 16'h7BDE;
`endif

        rst_n = 1'b1;
        load  = 1'b0;
        value = 16'h0;
        dp    = 4'h0;
        en    = 4'hF;
        #1 rst_n = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_nibble", 32'(nibble), 32'h0);
        chk("rst_dp", 32'(dp_out), 32'h0);
        chk("rst_fd", 32'(frame_done), 32'h0);
        rst_n = 1'b1;

        // Cycle k is observed at the negedge after the k-th posedge since release.
        for (int k = 0; k < 114; k++) begin
            if (k > 0) begin
                @(negedge clk);
                f = k / 16;
                s = (k / 4) % 4;
                c = k % 4;
                chk($sformatf("fd k=%0d", k), 32'(frame_done), 32'((k % 16) == 0));
                chk($sformatf("nib k=%0d", k), 32'(nibble), 32'(nib_f[f][4*s +: 4]));
                chk($sformatf("dp k=%0d", k), 32'(dp_out), 32'(dp_f[f][s]));
                chk($sformatf("an k=%0d", k), 32'(an), (c == 0) ? 32'hF : 32'(an_f[f][4*s +: 4]));
            end
            case (k)
                0:   begin value = 16'h1234; dp = 4'b0001; en = 4'hF; load = 1'b1; end
                1:   load = 1'b0;
                18:  begin value = 16'h9999; dp = 4'b1111; load = 1'b1; end
                19:  load = 1'b0;
                21:  begin value = 16'hAAAA; dp = 4'b0000; load = 1'b1; end
                22:  load = 1'b0;
                40:  begin value = 16'h7777; load = 1'b1; end
                41:  load = 1'b0;
                47:  begin value = 16'h5555; dp = 4'b0000; load = 1'b1; end
                48:  load = 1'b0;
                63:  en = 4'b0101;
                66:  begin value = 16'h0012; load = 1'b1; end
                67:  load = 1'b0;
                79:  en = 4'hF;
                85:  begin value = 16'h0000; dp = 4'b0100; load = 1'b1; end
                86:  load = 1'b0;
                111: begin value = 16'h8888; dp = 4'b1111; load = 1'b1; end
                112: load = 1'b0;
                default: ;
            endcase
        end

        // Asynchronous reset in the middle of a lit slot.
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_an", 32'(an), 32'hF);
        chk("mid_rst_nibble", 32'(nibble), 32'h0);
        chk("mid_rst_dp", 32'(dp_out), 32'h0);
        chk("mid_rst_fd", 32'(frame_done), 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int j = 1; j <= 16; j++) begin
            @(negedge clk);
            chk($sformatf("post_rst_fd j=%0d", j), 32'(frame_done), 32'(j == 16));
            chk($sformatf("post_rst_nib j=%0d", j), 32'(nibble), 32'h0);
            if (j == 1) chk("post_rst_an", 32'(an), 32'hE);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
